// File: rtl/nv_ram_rwsp_param.sv
// Parametrised two-port RAM (one write, one read port) with a two-stage registered read path.
// Define NV_RAM_RWSP_WR_BYPASS_EN for write-first forwarding into the output register; otherwise read-first.
module nv_ram_rwsp_param #(
  parameter int   DEPTH = 8,
  parameter int   WIDTH = 65,
  parameter int   AW    = 3,
  parameter logic FORCE_CONTENTION_ASSERTION_RESET_ACTIVE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    ra,
  input  logic             re,
  input  logic             ore,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  output logic             rd_oor,
  input  logic [AW-1:0]    wa,
  input  logic             we,
  input  logic [WIDTH-1:0] di,
  input  logic [31:0]      pwrbus_ram_pd
);

  // One extra bit so DEPTH == 2**AW is representable in the range compare.
  localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    ra_d;
  logic             ra_vld;
  logic             rd_in;
  logic             wr_in;
  logic [WIDTH-1:0] rd_data;
  logic             unused_ok;

  assign unused_ok = ^{pwrbus_ram_pd, FORCE_CONTENTION_ASSERTION_RESET_ACTIVE};
  assign wr_in     = ({1'b0, wa} < DEPTH_W);

  // Array is never reset; writes proceed even while rst is high.
  always_ff @(posedge clk) begin
    if (we && wr_in) begin
      mem[wa] <= di;
    end
  end

  always_comb begin
    rd_in   = ({1'b0, ra_d} < DEPTH_W);
    rd_data = '0;
    if (rd_in) begin
      rd_data = mem[ra_d];
    end
`ifdef NV_RAM_RWSP_WR_BYPASS_EN
    if (rd_in && we && (wa == ra_d)) begin
      rd_data = di;
    end
`endif
  end

  // Enables are plain qualifiers with no back-pressure: re loads the address
  // stage, ore loads the output stage from the address stage, each in one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ra_d     <= '0;
      ra_vld   <= 1'b0;
      dout     <= '0;
      dout_vld <= 1'b0;
      rd_oor   <= 1'b0;
    end else begin
      if (re) begin
        ra_d   <= ra;
        ra_vld <= 1'b1;
      end
      if (ore) begin
        dout     <= rd_data;
        dout_vld <= ra_vld & rd_in;
        rd_oor   <= ra_vld & ~rd_in;
      end
    end
  end

endmodule

// File: tb/tb_nv_ram_rwsp_param.sv
// Self-checking bench for nv_ram_rwsp_param: directed vector table, streaming,
// randomized traffic against a reference model, out-of-range and width sweeps.
module tb_nv_ram_rwsp_param;

`ifdef NV_RAM_RWSP_WR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int D0 = 8;
  localparam int W0 = 65;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // main instance (default parameters)
  logic          rst0 = 0, re0 = 0, ore0 = 0, we0 = 0;
  logic [2:0]    ra0 = 0, wa0 = 0;
  logic [W0-1:0] di0 = '0, dout0;
  logic          vld0, oor0;

  // out-of-range instance
  logic       rst1 = 0, re1 = 0, ore1 = 0, we1 = 0;
  logic [2:0] ra1 = 0, wa1 = 0;
  logic [7:0] di1 = '0, dout1;
  logic       vld1, oor1;

  // width-sweep instances share controls
  logic         rst23 = 0, re23 = 0, ore23 = 0, we23 = 0;
  logic [1:0]   ra23 = 0, wa23 = 0;
  logic [0:0]   di2 = '0, dout2;
  logic [127:0] di3 = '0, dout3;
  logic         vld2, oor2, vld3, oor3;

  nv_ram_rwsp_param u0 (
    .clk(clk), .rst(rst0), .ra(ra0), .re(re0), .ore(ore0), .dout(dout0),
    .dout_vld(vld0), .rd_oor(oor0), .wa(wa0), .we(we0), .di(di0), .pwrbus_ram_pd(32'h0));

  nv_ram_rwsp_param #(.DEPTH(6), .WIDTH(8), .AW(3)) u1 (
    .clk(clk), .rst(rst1), .ra(ra1), .re(re1), .ore(ore1), .dout(dout1),
    .dout_vld(vld1), .rd_oor(oor1), .wa(wa1), .we(we1), .di(di1), .pwrbus_ram_pd(32'h0));

  nv_ram_rwsp_param #(.DEPTH(3), .WIDTH(1), .AW(2)) u2 (
    .clk(clk), .rst(rst23), .ra(ra23), .re(re23), .ore(ore23), .dout(dout2),
    .dout_vld(vld2), .rd_oor(oor2), .wa(wa23), .we(we23), .di(di2), .pwrbus_ram_pd(32'h0));

  nv_ram_rwsp_param #(.DEPTH(3), .WIDTH(128), .AW(2)) u3 (
    .clk(clk), .rst(rst23), .ra(ra23), .re(re23), .ore(ore23), .dout(dout3),
    .dout_vld(vld3), .rd_oor(oor3), .wa(wa23), .we(we23), .di(di3), .pwrbus_ram_pd(32'h0));

  // reference model of u0: memory as an array, read pipeline as "last address read"
  logic [W0-1:0] m_mem [D0];
  logic [2:0]    m_addr = 0;
  logic          m_have = 0;
  logic [W0-1:0] m_dout = '0;
  logic          m_vld = 0, m_oor = 0;

  task automatic model_step();
    if (rst0) begin
      m_addr = 0; m_have = 0; m_dout = '0; m_vld = 0; m_oor = 0;
    end else begin
      if (ore0) begin
        if (int'(m_addr) < D0) begin
          m_dout = (BYP && we0 && wa0 == m_addr) ? di0 : m_mem[m_addr];
          m_vld  = m_have;
          m_oor  = 1'b0;
        end else begin
          m_dout = '0; m_vld = 1'b0; m_oor = m_have;
        end
      end
      if (re0) begin
        m_addr = ra0; m_have = 1'b1;
      end
    end
    if (we0 && int'(wa0) < D0) m_mem[wa0] = di0;
  endtask

  // inputs are changed 1 time unit after a rising edge and held to the next one
  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive0(input logic rst, input logic re, input logic ore, input logic we,
                        input logic [2:0] ra, input logic [2:0] wa, input logic [W0-1:0] di);
    rst0 = rst; re0 = re; ore0 = ore; we0 = we; ra0 = ra; wa0 = wa; di0 = di;
  endtask

  typedef struct {
    logic          rst, re, ore, we;
    logic [2:0]    ra, wa;
    logic [W0-1:0] di;
    logic [W0-1:0] exp_dout;
    logic          exp_vld, exp_oor;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic re, logic ore, logic we, logic [2:0] ra,
                              logic [2:0] wa, logic [W0-1:0] di, logic [W0-1:0] ed,
                              logic ev, logic eo);
    vec_t v;
    v.rst = rst; v.re = re; v.ore = ore; v.we = we; v.ra = ra; v.wa = wa; v.di = di;
    v.exp_dout = ed; v.exp_vld = ev; v.exp_oor = eo;
    return v;
  endfunction

  localparam logic [W0-1:0] K = 65'h1_2345_6789_ABCD_EF01;

  initial begin
    logic [W0-1:0] rd_first;
    logic [127:0]  one;
    logic [127:0]  e3;
    logic          e2;
    rd_first = BYP ? 65'hBB : 65'hAA;

    //        rst re ore we ra wa di       exp_dout  vld oor
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,     0,        0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,     0,        0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 3, K,     0,        0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 3, 0, 0,     0,        0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0,     K,        1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 5, 'hAA,  K,        1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 'h10,  K,        1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 5, 0, 0,     K,        1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 5, 'hBB,  rd_first, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0,     'hBB,     1, 0));
    vecs.push_back(mk(0, 1, 0, 1, 2, 2, 'h55,  'hBB,     1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0,     'h55,     1, 0));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 'h55, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 3, 0, 0,     0,        0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0,     'h10,     0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 2, 0, 0,     'h10,     0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0,     'h55,     1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 1, 'h77,  'h55,     1, 0));
    vecs.push_back(mk(0, 1, 0, 1, 6, 6, 'h66,  'h55,     1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0,     'h66,     1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 4, 'h44,  0,        0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 4, 0, 0,     0,        0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0,     'h44,     1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 7, 'h1,   'h44,     1, 0));
    vecs.push_back(mk(0, 1, 0, 1, 7, 7, 'h2,   'h44,     1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0,     'h2,      1, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive0(vecs[i].rst, vecs[i].re, vecs[i].ore, vecs[i].we, vecs[i].ra, vecs[i].wa, vecs[i].di);
      tick();
      check($sformatf("vec%0d_dout", i), dout0, vecs[i].exp_dout);
      check($sformatf("vec%0d_vld", i), vld0, vecs[i].exp_vld);
      check($sformatf("vec%0d_oor", i), oor0, vecs[i].exp_oor);
    end

    // streaming: fill, then re+ore every cycle; ra_d is 7 from the table
    for (int i = 0; i < D0; i++) begin
      drive0(0, 0, 0, 1, 0, 3'(i), W0'(i * 'h11));
      tick();
    end
    for (int k = 0; k <= D0; k++) begin
      drive0(0, 1, 1, 0, 3'(k % D0), 0, 0);
      tick();
      check($sformatf("stream%0d_dout", k), dout0, 128'(((k + 7) % D0) * 'h11));
      check($sformatf("stream%0d_vld", k), vld0, 1'b1);
    end

    // randomized traffic against the model (all words written above)
    for (int n = 0; n < 400; n++) begin
      drive0(($urandom_range(39, 0) == 0), $urandom_range(1, 0), $urandom_range(1, 0),
             $urandom_range(1, 0), 3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)),
             {1'($urandom_range(1, 0)), $urandom, $urandom});
      tick();
      check($sformatf("rnd%0d_dout", n), dout0, m_dout);
      check($sformatf("rnd%0d_vld", n), vld0, m_vld);
      check($sformatf("rnd%0d_oor", n), oor0, m_oor);
    end
    drive0(0, 0, 0, 0, 0, 0, 0);

    // out-of-range protection, DEPTH=6
    rst1 = 1; tick(); rst1 = 0;
    check("oor_rst_dout", dout1, 0);
    check("oor_rst_vld", vld1, 0);
    check("oor_rst_oor", oor1, 0);
    for (int a = 0; a < 6; a++) begin
      we1 = 1; wa1 = 3'(a); di1 = 8'(a * 'h21 + 3); tick();
    end
    wa1 = 7; di1 = 8'hFF; tick();
    wa1 = 6; di1 = 8'hEE; tick();
    we1 = 0;
    for (int a = 0; a < 6; a++) begin
      re1 = 1; ra1 = 3'(a); tick();
      re1 = 0; ore1 = 1; tick(); ore1 = 0;
      check($sformatf("oor_rd%0d_dout", a), dout1, 128'(8'(a * 'h21 + 3)));
      check($sformatf("oor_rd%0d_vld", a), vld1, 1);
      check($sformatf("oor_rd%0d_oor", a), oor1, 0);
    end
    re1 = 1; ra1 = 7; tick();
    re1 = 0; ore1 = 1; tick(); ore1 = 0;
    check("oor7_dout", dout1, 0);
    check("oor7_vld", vld1, 0);
    check("oor7_oor", oor1, 1);
    re1 = 1; ra1 = 2; tick();
    re1 = 0; ore1 = 1; tick(); ore1 = 0;
    check("oor_back_dout", dout1, 'h45);
    check("oor_back_vld", vld1, 1);
    check("oor_back_oor", oor1, 0);

    // width sweep: WIDTH=1 and WIDTH=128, DEPTH=3
    rst23 = 1; tick(); rst23 = 0;
    one = 128'd1;
    for (int b = 0; b < 128; b++) begin
      for (int a = 0; a < 3; a++) begin
        we23 = 1; wa23 = 2'(a); di3 = one << ((b + a) % 128); di2 = 1'((b + a) % 2);
        tick();
      end
      we23 = 0;
      for (int a = 0; a < 3; a++) begin
        re23 = 1; ra23 = 2'(a); tick();
        re23 = 0; ore23 = 1; tick(); ore23 = 0;
        e3 = one << ((b + a) % 128);
        e2 = 1'((b + a) % 2);
        check($sformatf("w128_b%0d_a%0d", b, a), dout3, e3);
        check($sformatf("w1_b%0d_a%0d", b, a), dout2, e2);
        check($sformatf("wvld_b%0d_a%0d", b, a), vld3 & vld2, 1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nv_ram_rwsp_param.md
Name: nv_ram_rwsp_param

Overview:
- Parametrised two-port RAM model for FPGA builds: one write port and one read port on a single clock.
- Read path has two stages: a registered read address (captured on re), then a registered output (captured on ore).
- Adds these over the fixed-size models:
  - arbitrary depth and width;
  - data-valid tracking on the output;
  - out-of-range address protection for non-power-of-two depths;
  - optional same-cycle write-to-read forwarding.
- Replaces the per-size rwsp models across the design.

Parameters:
- DEPTH, 8, number of words; any value >= 2, need not be a power of two.
- WIDTH, 65, data width in bits, >= 1.
- AW, 3, address width; must satisfy 2**AW >= DEPTH.
- FORCE_CONTENTION_ASSERTION_RESET_ACTIVE, 1'b0, kept for interface compatibility; no functional effect.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- ra  input  AW  read address.
- re  input  1  read enable; captures ra into the address stage.
- ore  input  1  output enable; captures array data into the output register.
- dout  output  WIDTH  registered read data.
- dout_vld  output  1  dout holds data from a valid, in-range read.
- rd_oor  output  1  registered flag: the last ore capture used an out-of-range address.
- wa  input  AW  write address.
- we  input  1  write enable.
- di  input  WIDTH  write data.
- pwrbus_ram_pd  input  32  power-control bus; ignored by the model.

Behaviour:
- Reset (rst=1 at a clk edge):
  - ra_d=0, ra_vld=0, dout=0, dout_vld=0, rd_oor=0.
  - Array contents are not reset and not altered.
  - Reset has priority over re/ore/we for the pipeline registers.
  - Writes with we=1 during reset are still performed.
- Write: we=1 and wa<DEPTH -> M[wa]<=di at the edge. we=1 and wa>=DEPTH -> no array change.
- Address stage:
  - re=1 -> ra_d<=ra, ra_vld<=1.
  - re=0 -> ra_d and ra_vld hold.
  - ra_vld stays 1 once set until the next reset.
- Output stage, on ore=1:
  - dout<=(ra_d<DEPTH) ? M[ra_d] : 0.
  - dout_vld<=ra_vld & (ra_d<DEPTH).
  - rd_oor<=ra_vld & (ra_d>=DEPTH).
- Output stage, on ore=0: dout, dout_vld and rd_oor hold.
- Latency:
  - re at edge N, ore at edge N+1 -> data visible after edge N+1, i.e. 2 cycles from the address.
  - re and ore may be asserted in the same cycle; ore then captures using the previous ra_d, which is standard pipelined overlap.
- Read-during-write, same cycle, we=1, ore=1, wa==ra_d: handling depends on the optional feature below.
- Write to an address other than ra_d in the ore cycle: no interaction.
- Back-to-back writes to the same address: last write wins.
- Simultaneous we and re to the same address: ra_d captures the address. A later ore sees the new data, because the write has completed by then.
- Reset mid-read:
  - in-flight address and output are discarded;
  - dout_vld=0 until a fresh re then ore sequence completes.

Optional Feature:
- Macro: NV_RAM_RWSP_WR_BYPASS_EN.
- Defined:
  - on ore=1, we=1, wa==ra_d, ra_d<DEPTH, dout<=di (write-first forwarding);
  - dout_vld follows the normal rule.
- Undefined:
  - the same case yields dout<=old M[ra_d] (read-first);
  - the array is still updated with di.
- Both builds must be otherwise cycle-identical.

Test Plan:
- Reset then basic read: rst 2 cycles; write M[3]=0x1_2345_6789_ABCD_EF01; re ra=3; next cycle ore -> dout=0x1_2345_6789_ABCD_EF01, dout_vld=1, rd_oor=0.
- Pipelined streaming: fill M[0..7]=i*0x11; assert re and ore every cycle with ra=0..7 -> dout sequence 0x00,0x11,...,0x77, one per cycle, one cycle behind ra_d.
- Read-during-write: M[5]=0xAA; ra_d=5; same cycle we=1, wa=5, di=0xBB, ore=1:
  - with NV_RAM_RWSP_WR_BYPASS_EN defined -> dout=0xBB;
  - without it -> dout=0xAA;
  - in both builds a subsequent read returns 0xBB.
- Out-of-range, DEPTH=6, AW=3: write wa=7, di=0xFF -> no array change; re ra=7 then ore -> dout=0, dout_vld=0, rd_oor=1; then read ra=2 -> rd_oor=0.
- Hold and reset mid-op: after a valid read with dout=0x55, hold ore=0 for 5 cycles -> dout stays 0x55. Assert rst with re=1 -> dout=0, dout_vld=0, ra_vld=0; array contents retained (a read of the same address after reset returns 0x55).
- Width sweep: WIDTH=1 and WIDTH=128, DEPTH=3 -> walking-ones write/read on all addresses matches, with no truncation.
